sat_addsub_pipe: RTL

//  Parametrised, 2-stage pipelined signed saturating add/subtract unit with an internal accumulator.
//  - Successor to the fixed-width combinational saturating subtractor.
//  - Adds: width parameter, add/sub/accumulate modes, valid/ready handshake, saturation flag.
//  - Sits between fixed-point datapath producers (filters, controllers) and downstream consumers.

---
 rtl/sat_addsub_pipe_pkg.sv | 23 ++
 rtl/sat_addsub_core.sv | 36 +++
 rtl/sat_addsub_pipe.sv | 117 +++++++++++
 3 files changed

// File: rtl/sat_addsub_pipe_pkg.sv
// Shared op encodings and saturation-limit helpers for the saturating add/sub datapath.
package sat_addsub_pipe_pkg;

   localparam int unsigned OP_W  = 2;
   localparam int unsigned LIM_W = 64;

   typedef logic [OP_W-1:0] op_t;

   localparam op_t OP_ADD     = 2'b00;
   localparam op_t OP_SUB     = 2'b01;
   localparam op_t OP_ACC_ADD = 2'b10;
   localparam op_t OP_ACC_SUB = 2'b11;

   // Limits are built in a wide word; callers truncate to their width.
   function automatic logic [LIM_W-1:0] sat_max(input int unsigned w);
      return (LIM_W'(1) << (w - 1)) - LIM_W'(1);
   endfunction

   function automatic logic [LIM_W-1:0] sat_min(input int unsigned w);
      return ~sat_max(w);
   endfunction

endpackage

// File: rtl/sat_addsub_core.sv
// Combinational signed saturating add/subtract: result = sat(x +/- y).
module sat_addsub_core
   import sat_addsub_pipe_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             sub,
   output logic [WIDTH-1:0] result,
   output logic             sat
);

   localparam logic [WIDTH-1:0] MAX_V = WIDTH'(sat_max(WIDTH));
   localparam logic [WIDTH-1:0] MIN_V = WIDTH'(sat_min(WIDTH));

   logic [WIDTH:0] xe;
   logic [WIDTH:0] ye;
   logic [WIDTH:0] raw;

   assign xe = {x[WIDTH-1], x};
   assign ye = {y[WIDTH-1], y};

   // One guard bit: overflow shows as disagreement between the top two bits.
   always_comb begin
      result = '0;
      sat    = 1'b0;
      raw    = sub ? (xe - ye) : (xe + ye);
      result = raw[WIDTH-1:0];
      if (raw[WIDTH] != raw[WIDTH-1]) begin
         sat    = 1'b1;
         result = raw[WIDTH] ? MIN_V : MAX_V;
      end
   end

endmodule

// File: rtl/sat_addsub_pipe.sv
// Two-stage pipelined signed saturating add/sub unit with accumulator and valid/ready handshake.
// Optional sticky saturation flag enabled by defining SAT_STICKY_EN.
module sat_addsub_pipe
   import sat_addsub_pipe_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OP_W-1:0]  op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             acc_clr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
`ifdef SAT_STICKY_EN
   output logic             sat_sticky,
   input  logic             sticky_clr,
`endif
   output logic             sat
);

   logic             s1_valid;
   op_t              s1_op;
   logic [WIDTH-1:0] s1_a;
   logic [WIDTH-1:0] s1_b;
   logic [WIDTH-1:0] acc;

   logic             s2_adv;
   logic             s1_adv;
   logic             s2_load;
   logic             acc_mode;
   logic [WIDTH-1:0] core_x;
   logic [WIDTH-1:0] core_y;
   logic [WIDTH-1:0] core_result;
   logic             core_sat;

   assign s2_adv   = !out_valid || out_ready;
   assign s1_adv   = !s1_valid || s2_adv;
   assign in_ready = s1_adv;
   assign s2_load  = s1_valid && s2_adv;

   // Accumulate ops use acc as the left operand and a as the right one.
   assign acc_mode = s1_op[1];
   assign core_x   = acc_mode ? acc  : s1_a;
   assign core_y   = acc_mode ? s1_a : s1_b;

   sat_addsub_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .x      (core_x),
      .y      (core_y),
      .sub    (s1_op[0]),
      .result (core_result),
      .sat    (core_sat)
   );

   // Stage 1: operand capture.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid <= 1'b0;
         s1_op    <= OP_ADD;
         s1_a     <= '0;
         s1_b     <= '0;
      end else if (s1_adv) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_op <= op;
            s1_a  <= a;
            s1_b  <= b;
         end
      end
   end

   // Stage 2: result register, held while the consumer stalls.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid <= 1'b0;
         result    <= '0;
         sat       <= 1'b0;
      end else if (s2_adv) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            result <= core_result;
            sat    <= core_sat;
         end
      end
   end

   // Clear wins over a coincident accumulate load; the result still used the old acc.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc <= '0;
      end else if (acc_clr) begin
         acc <= '0;
      end else if (s2_load && acc_mode) begin
         acc <= core_result;
      end
   end

`ifdef SAT_STICKY_EN
   // A new saturation takes priority over a same-cycle clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sat_sticky <= 1'b0;
      end else if (s2_load && core_sat) begin
         sat_sticky <= 1'b1;
      end else if (sticky_clr) begin
         sat_sticky <= 1'b0;
      end
   end
`endif

endmodule
